// File: rtl/pipe_skid_32_if.sv
// pipe_skid_32_if
//   Handshake bundle for the pipe_skid_32 elastic stage. It carries both the
//   upstream (in_*) channel and the downstream (out_*) channel plus the
//   occupancy count, so the stage connects through a single port.
//
//   Signals:
//     in_data   - word offered by upstream
//     in_valid  - upstream has a word on in_data
//     in_ready  - stage can accept a word (driven by the stage, registered)
//     out_data  - word presented downstream (driven by the stage, registered)
//     out_valid - out_data holds a valid word (driven by the stage, registered)
//     out_ready - downstream accepts out_data this cycle
//     count     - number of words held in the stage (0, 1 or 2)
//
//   Modports:
//     slave  - the stage itself (consumes in_*, produces out_* and count)
//     master - the environment around the stage (drives in_* and out_ready)

interface pipe_skid_32_if #(
    parameter int WIDTH = 32
);

    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       count;

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_valid,
        input  out_ready,
        output count
    );

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_valid,
        output out_ready,
        input  count
    );

endinterface

// File: rtl/pipe_skid_32.sv
// pipe_skid_32
//   Elastic two-entry pipeline stage with valid/ready handshakes on both
//   sides. Accepted words land in a main register that drives out_data
//   directly. When downstream stalls while a new word is being accepted, that
//   word is caught in a skid register, so in_ready can be a registered signal
//   and the stage still sustains one word per cycle.
//
//   Ports:
//     clk  - system clock, all state changes on the rising edge
//     rst  - synchronous reset, active-low
//     bus  - pipe_skid_32_if.slave handshake bundle:
//              in_data / in_valid / in_ready    upstream channel
//              out_data / out_valid / out_ready downstream channel
//              count                            occupancy (0, 1 or 2)
//
//   Every output comes straight from a flop; the handshake inputs only feed
//   next-state logic, never an output path.

module pipe_skid_32 #(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst,
    pipe_skid_32_if.slave  bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] main_next;
    logic [WIDTH-1:0] skid_q;
    logic [WIDTH-1:0] skid_next;

    // Output flops, loaded from a decode of the next state so they always
    // match the state register without any combinational path to the ports.
    logic             out_valid_q;
    logic             out_valid_next;
    logic             in_ready_q;
    logic             in_ready_next;
    logic [1:0]       count_q;
    logic [1:0]       count_next;

    logic             in_acc;
    logic             out_acc;

    // Transfers are qualified with the registered ready/valid this stage is
    // currently advertising, never with anything derived from the inputs.
    assign in_acc  = bus.in_valid & in_ready_q;
    assign out_acc = out_valid_q & bus.out_ready;

    // Next-state, datapath and output decode. A simultaneous accept and
    // release in BUSY replaces the main register in place, which is what
    // gives full throughput; the skid register is only written when the
    // word in flight cannot move on.
    always_comb begin
        state_next = state;
        main_next  = main_q;
        skid_next  = skid_q;

        unique case (state)
            EMPTY: begin
                if (in_acc) begin
                    main_next  = bus.in_data;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (in_acc && out_acc) begin
                    main_next  = bus.in_data;
                    state_next = BUSY;
                end else if (in_acc) begin
                    skid_next  = bus.in_data;
                    state_next = FULL;
                end else if (out_acc) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                if (out_acc) begin
                    main_next  = skid_q;
                    state_next = BUSY;
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase

        out_valid_next = 1'b0;
        in_ready_next  = 1'b1;
        count_next     = 2'd0;
        unique case (state_next)
            EMPTY: begin
                out_valid_next = 1'b0;
                in_ready_next  = 1'b1;
                count_next     = 2'd0;
            end
            BUSY: begin
                out_valid_next = 1'b1;
                in_ready_next  = 1'b1;
                count_next     = 2'd1;
            end
            FULL: begin
                out_valid_next = 1'b1;
                in_ready_next  = 1'b0;
                count_next     = 2'd2;
            end
            default: begin
                out_valid_next = 1'b0;
                in_ready_next  = 1'b1;
                count_next     = 2'd0;
            end
        endcase
    end

    // State, data and output registers. Reset clears both data registers so
    // a discarded word can never reappear on out_data.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            count_q     <= 2'd0;
        end else begin
            state       <= state_next;
            main_q      <= main_next;
            skid_q      <= skid_next;
            out_valid_q <= out_valid_next;
            in_ready_q  <= in_ready_next;
            count_q     <= count_next;
        end
    end

    assign bus.out_data  = main_q;
    assign bus.out_valid = out_valid_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.count     = count_q;

    // Occupancy can never exceed two words.
    assert property (@(posedge clk) disable iff (!rst) count_q != 2'd3);

    // A stalled output word must stay put until downstream takes it.
    assert property (@(posedge clk) disable iff (!rst)
        (out_valid_q && !bus.out_ready) |=> (out_valid_q && $stable(main_q)));

    // in_ready only drops when the stage is holding two words.
    assert property (@(posedge clk) disable iff (!rst)
        (!in_ready_q) |-> (count_q == 2'd2));

endmodule

// File: tb/tb_pipe_skid_32.sv
// tb_pipe_skid_32
//   Directed and randomised bench for pipe_skid_32. Inputs change 1 time unit
//   after each rising edge and outputs are sampled at the same point, so each
//   sample shows the state produced by the edge just taken.

module tb_pipe_skid_32;

    localparam int WIDTH = 32;

    logic clk;
    logic rst;

    int checks;
    int errors;

    pipe_skid_32_if #(.WIDTH(WIDTH)) bus ();

    pipe_skid_32 #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge and settle just past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst          = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hFFFF_FFFF;
        bus.out_ready = 1'b0;
        step();
        step();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_out_valid got %b want 0", bus.out_valid);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_in_ready got %b want 1", bus.in_ready);
        end
        checks++;
        if (bus.count !== 2'd0) begin
            errors++;
            $display("[TB] FAIL reset_count got %0d want 0", bus.count);
        end
        checks++;
        if (bus.out_data !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_out_data got %h want 00000000", bus.out_data);
        end
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        step();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.count !== 2'd0) begin
            errors++;
            $display("[TB] FAIL reset_no_capture got valid=%b count=%0d want valid=0 count=0",
                     bus.out_valid, bus.count);
        end
    endtask

    task automatic test_streaming();
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = i;
            step();
            checks++;
            if (bus.out_data !== 32'(i) || bus.out_valid !== 1'b1) begin
                errors++;
                $display("[TB] FAIL stream_data[%0d] got %h valid=%b want %h valid=1",
                         i, bus.out_data, bus.out_valid, 32'(i));
            end
            checks++;
            if (bus.in_ready !== 1'b1 || bus.count !== 2'd1) begin
                errors++;
                $display("[TB] FAIL stream_flow[%0d] got ready=%b count=%0d want ready=1 count=1",
                         i, bus.in_ready, bus.count);
            end
        end
    endtask

    task automatic test_drain();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.count !== 2'd0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL drain_state got valid=%b count=%0d ready=%b want valid=0 count=0 ready=1",
                     bus.out_valid, bus.count, bus.in_ready);
        end
        checks++;
        if (bus.out_data !== 32'h0000_0008) begin
            errors++;
            $display("[TB] FAIL drain_main_kept got %h want 00000008", bus.out_data);
        end
    endtask

    task automatic test_stall_skid();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'hA5A5_A5A5;
        step();
        checks++;
        if (bus.count !== 2'd1 || bus.out_data !== 32'hA5A5_A5A5) begin
            errors++;
            $display("[TB] FAIL stall_first got count=%0d data=%h want count=1 data=a5a5a5a5",
                     bus.count, bus.out_data);
        end
        bus.in_data = 32'h5A5A_5A5A;
        step();
        checks++;
        if (bus.count !== 2'd2 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_full got count=%0d ready=%b want count=2 ready=0",
                     bus.count, bus.in_ready);
        end
        bus.in_data = 32'hDEAD_BEEF;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (bus.out_data !== 32'hA5A5_A5A5 || bus.count !== 2'd2 || bus.in_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL stall_hold[%0d] got data=%h count=%0d ready=%b want a5a5a5a5 2 0",
                         i, bus.out_data, bus.count, bus.in_ready);
            end
        end
        bus.out_ready = 1'b1;
        step();
        checks++;
        if (bus.out_data !== 32'h5A5A_5A5A || bus.count !== 2'd1 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL skid_release got data=%h count=%0d ready=%b want 5a5a5a5a 1 1",
                     bus.out_data, bus.count, bus.in_ready);
        end
        step();
        checks++;
        if (bus.out_data !== 32'hDEAD_BEEF || bus.count !== 2'd1 || bus.out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL skid_late_word got data=%h count=%0d valid=%b want deadbeef 1 1",
                     bus.out_data, bus.count, bus.out_valid);
        end
        bus.in_valid = 1'b0;
        step();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.count !== 2'd0) begin
            errors++;
            $display("[TB] FAIL skid_no_dup got valid=%b count=%0d want 0 0",
                     bus.out_valid, bus.count);
        end
    endtask

    task automatic test_mid_reset();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h1111_1111;
        step();
        bus.in_data = 32'h2222_2222;
        step();
        checks++;
        if (bus.count !== 2'd2) begin
            errors++;
            $display("[TB] FAIL midrst_full got count=%0d want 2", bus.count);
        end
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        step();
        rst = 1'b1;
        checks++;
        if (bus.count !== 2'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
            bus.out_data !== 32'h0) begin
            errors++;
            $display("[TB] FAIL midrst_empty got count=%0d valid=%b ready=%b data=%h want 0 0 1 00000000",
                     bus.count, bus.out_valid, bus.in_ready, bus.out_data);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h3333_3333;
        step();
        checks++;
        if (bus.out_data !== 32'h3333_3333 || bus.count !== 2'd1) begin
            errors++;
            $display("[TB] FAIL midrst_first got data=%h count=%0d want 33333333 1",
                     bus.out_data, bus.count);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.count !== 2'd0) begin
            errors++;
            $display("[TB] FAIL midrst_only_one got valid=%b count=%0d want 0 0",
                     bus.out_valid, bus.count);
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] model[$];
        logic             in_acc_m;
        logic             out_acc_m;
        int               outputs_seen;

        outputs_seen  = 0;
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        step();
        rst = 1'b1;

        for (int n = 0; n < 10000; n++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 1) != 0);
            bus.in_data   = $urandom();
            // Model readiness follows the queue depth before the edge.
            in_acc_m  = bus.in_valid && (model.size() < 2);
            out_acc_m = bus.out_ready && (model.size() > 0);
            if (in_acc_m && model.size() < 2) begin
                // captured below after the pop
            end
            if (out_acc_m) begin
                void'(model.pop_front());
                outputs_seen++;
            end
            if (in_acc_m) model.push_back(bus.in_data);
            step();

            checks++;
            if (bus.count !== 2'(model.size())) begin
                errors++;
                $display("[TB] FAIL rand_count[%0d] got %0d want %0d", n, bus.count, model.size());
            end
            checks++;
            if (bus.out_valid !== (model.size() > 0) || bus.in_ready !== (model.size() < 2)) begin
                errors++;
                $display("[TB] FAIL rand_flags[%0d] got valid=%b ready=%b want valid=%b ready=%b",
                         n, bus.out_valid, bus.in_ready, model.size() > 0, model.size() < 2);
            end
            if (model.size() > 0) begin
                checks++;
                if (bus.out_data !== model[0]) begin
                    errors++;
                    $display("[TB] FAIL rand_data[%0d] got %h want %h", n, bus.out_data, model[0]);
                end
            end
        end
        $display("[TB] random phase consumed %0d words", outputs_seen);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        #1;

        test_reset();
        test_streaming();
        test_drain();
        test_stall_skid();
        test_mid_reset();
        test_random();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_skid_32.md
Name: pipe_skid_32

Overview:
- Elastic 2-entry pipeline stage with a valid/ready handshake on both sides. It is the consuming end of a register-to-register transfer.
- Upstream writes are accepted into a main register. When downstream stalls, the word in flight is caught in a skid register, so full throughput holds without a combinational ready path.
- It sits between ALU pipeline stages wherever a plain 32-bit capture register must tolerate back-pressure.

Parameters:
- WIDTH, 32, data width in bits of in_data/out_data and both internal registers.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous reset, active-low. Sampled on the rising edge of clk.
- in_data  input  WIDTH  word offered by upstream.
- in_valid  input  1  upstream has a word on in_data.
- in_ready  output  1  stage can accept a word (registered).
- out_data  output  WIDTH  word presented downstream (registered; equals the main register).
- out_valid  output  1  out_data holds a valid word (registered).
- out_ready  input  1  downstream accepts out_data this cycle.
- count  output  2  occupancy: 0, 1 or 2 words held.

Behaviour:
- Handshake: a transfer occurs on any rising edge where valid and ready are both 1.
  - in_acc = in_valid & in_ready; out_acc = out_valid & out_ready.
  - in_valid/out_ready may toggle freely; the stage never depends on them combinationally for its outputs.
- Storage: main register (drives out_data) and skid register; state is one of EMPTY, BUSY or FULL.
- Decoded outputs, all registered, no input-to-output combinational path:
  - EMPTY: out_valid=0, in_ready=1, count=0.
  - BUSY: out_valid=1, in_ready=1, count=1.
  - FULL: out_valid=1, in_ready=0, count=2.
- Reset (rst==0 at a clk edge): state EMPTY; out_valid=0, in_ready=1, count=0, out_data=0, skid=0.
  - All other inputs are ignored in that cycle.
  - Reset mid-transfer discards both held words; no handshake completes on a reset edge.
- Transitions:
  - EMPTY, in_acc: main<=in_data, go to BUSY. Otherwise stay EMPTY (out_ready ignored, since out_valid=0).
  - BUSY, in_acc & out_acc: main<=in_data, stay BUSY. This gives full throughput, one word per cycle.
  - BUSY, in_acc only: skid<=in_data, go to FULL. main is unchanged.
  - BUSY, out_acc only: go to EMPTY. main retains its old value but out_valid=0.
  - BUSY, neither: hold.
  - FULL, out_acc: main<=skid, go to BUSY. in_valid is ignored because in_ready=0.
  - FULL, no out_acc: hold both registers.
- Latency: a word accepted at edge N appears on out_data with out_valid=1 after edge N (visible in cycle N+1). Minimum latency is 1 cycle.
- Stability: while out_valid=1 and out_ready=0, out_data must not change.
- Ordering: strict FIFO; no word is duplicated or dropped.
- Width rule: data is passed bit-exact with no truncation or extension. The skid register is exactly WIDTH bits.
- in_ready deasserts only in FULL, and returns to 1 on the edge where FULL drains via out_acc.

Test Plan:
- Reset: hold rst=0 for 2 cycles with in_valid=1, in_data=32'hFFFF_FFFF → out_valid=0, in_ready=1, count=0, out_data=0. No word is captured.
- Streaming: out_ready=1, send 32'h0000_0001..32'h0000_0008 on consecutive cycles.
  - out_data shows 1..8 on consecutive cycles, each one cycle after acceptance.
  - in_ready stays 1 and count stays 1 during the stream.
- Stall/skid:
  - Send 32'hA5A5_A5A5 then 32'h5A5A_5A5A with out_ready=0 → count=2, in_ready=0, out_data=32'hA5A5_A5A5 held stable.
  - Offer 32'hDEAD_BEEF while FULL → it is not accepted.
  - Raise out_ready: outputs are A5A5_A5A5, then 5A5A_5A5A, then DEAD_BEEF (accepted once in_ready returns to 1).
- Drain: from BUSY with out_ready=1, in_valid=0 → out_valid drops to 0 next cycle, count=0.
- Mid-operation reset: reach FULL with 32'h1111_1111/32'h2222_2222, pulse rst=0 for one edge → EMPTY, out_data=0. The next accepted word 32'h3333_3333 is the first output.
- Random: 10k cycles of random in_valid/out_ready checked against a reference queue model.
  - Output order and values match, no loss or duplication.
  - count never exceeds 2.
  - out_data is stable under stall.
